// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32I pipeline control logic: result selects,
// forwarding selects and the data-memory wait FSM states.
package pipeline_pkg;

    localparam logic [1:0] RESULT_ALU = 2'b00;
    localparam logic [1:0] RESULT_MEM = 2'b01;
    localparam logic [1:0] RESULT_PC4 = 2'b10;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } mem_state_t;

    // x0 is hardwired to zero, so a write to it never creates a dependency
    function automatic logic regMatch(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/forward_select.sv
// Forwarding select for one execute-stage source operand; the memory stage
// holds the younger result, so it wins over writeback.
module forward_select
    import pipeline_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rdM,
    input  logic       i_regWriteM,
    input  logic [4:0] i_rdW,
    input  logic       i_regWriteW,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_regWriteM && regMatch(i_rdM, i_rs)) begin
            o_sel = FWD_M;
        end else if (i_regWriteW && regMatch(i_rdW, i_rs)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage RV32I core: forwarding, load-use and branch
// handling, data-memory wait stall with timeout, and stall/flush counters.
module hazard_unit
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic             RegWriteE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    mem_state_t       r_state;
    mem_state_t       w_stateNext;
    logic [WAIT_W-1:0] r_waitCnt;
    logic [WAIT_W-1:0] w_waitCntNext;
    logic              r_memTimeout;
    logic [CNT_W-1:0]  r_stallCount;
    logic [CNT_W-1:0]  r_flushCount;

    logic       w_memStall;
    logic       w_loadUse;
    logic       w_branch;
    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;
    logic       w_regWriteEUnused;

    // Only the load itself creates a use hazard; RegWriteE is carried for completeness
    assign w_regWriteEUnused = RegWriteE;

    forward_select u_fwdA (
        .i_rs        (Rs1E),
        .i_rdM       (RdM),
        .i_regWriteM (RegWriteM),
        .i_rdW       (RdW),
        .i_regWriteW (RegWriteW),
        .o_sel       (w_fwdA)
    );

    forward_select u_fwdB (
        .i_rs        (Rs2E),
        .i_rdM       (RdM),
        .i_regWriteM (RegWriteM),
        .i_rdW       (RdW),
        .i_regWriteW (RegWriteW),
        .o_sel       (w_fwdB)
    );

    assign w_memStall = MemReqM && !MemReadyM;
    assign w_loadUse  = !w_memStall && (ResultSrcE == RESULT_MEM)
                        && (regMatch(RdE, Rs1D) || regMatch(RdE, Rs2D));
    // A redirect held in E during a memory stall fires once the stall drops
    assign w_branch   = !w_memStall && PCSrcE;

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        FlushW    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (rst_n) begin
            StallF    = w_memStall || (w_loadUse && !w_branch);
            StallD    = w_memStall || (w_loadUse && !w_branch);
            StallE    = w_memStall;
            StallM    = w_memStall;
            FlushD    = w_branch;
            FlushE    = w_branch || w_loadUse;
            FlushW    = w_memStall;
            ForwardAE = w_fwdA;
            ForwardBE = w_fwdB;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = r_waitCnt;
        case (r_state)
            RUN: begin
                w_waitCntNext = '0;
                if (w_memStall) begin
                    w_stateNext = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (MemReadyM || !MemReqM) begin
                    w_stateNext   = RUN;
                    w_waitCntNext = '0;
                end else if (r_waitCnt != WAIT_MAX) begin
                    w_waitCntNext = r_waitCnt + WAIT_W'(1);
                end
            end
            default: begin
                w_stateNext   = RUN;
                w_waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_waitCnt    <= '0;
            r_memTimeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
            if (w_waitCntNext == WAIT_MAX) begin
                r_memTimeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCount <= '0;
            r_flushCount <= '0;
        end else begin
            if (StallF && !(&r_stallCount)) begin
                r_stallCount <= r_stallCount + CNT_W'(1);
            end
            if (FlushE && !(&r_flushCount)) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

    assign MemTimeout = r_memTimeout;
    assign StallCount = r_stallCount;
    assign FlushCount = r_flushCount;

endmodule
